// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: executes START, WRITE, READ and STOP commands one at a time,
// each built from four SCL quarters, with clock stretching and write arbitration detection.
module i2c_byte_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [1:0] i_cmd,
  input  logic [7:0] i_tx_data,
  input  logic       i_ack_send,
  output logic       o_done,
  output logic [7:0] o_rx_data,
  output logic       o_ack_rcvd,
  output logic       o_arb_lost,
  output logic       o_scl_write,
  output logic       o_sda_write,
  input  logic       i_scl_read,
  input  logic       i_sda_read
);

  typedef enum logic [1:0] {StIdle, StStart, StBit, StStop} state_e;
  typedef enum logic [1:0] {CmdStart, CmdWrite, CmdRead, CmdStop} cmd_e;

  localparam logic [15:0] Reload = 16'(CLK_DIV - 1);

  state_e      state_q, state_d;
  cmd_e        cmd_q, cmd_d;
  logic [1:0]  quarter_q, quarter_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  slot_q, slot_d;
  logic [7:0]  tx_q, tx_d;
  logic        ack_send_q, ack_send_d;
  logic [7:0]  rx_q, rx_d;
  logic        ack_rcvd_q, ack_rcvd_d;
  logic        scl_q, scl_d;
  logic        sda_q, sda_d;
  logic        done_q, done_d;
  logic        arb_q, arb_d;
  logic        stall;
  logic        arb_hit;

  // {scl, sda} levels driven for the whole of a given quarter.
  function automatic logic [1:0] line_levels(state_e st, logic [1:0] q, logic [3:0] slot,
                                             cmd_e cmd, logic [7:0] tx, logic ack_send);
    logic [1:0] lv;
    lv = 2'b11;
    case (st)
      StStart: lv = (q == 2'd3) ? 2'b00 : ((q == 2'd2) ? 2'b10 : 2'b11);
      StStop:  lv = (q == 2'd0) ? 2'b00 : ((q == 2'd1) ? 2'b10 : 2'b11);
      StBit: begin
        lv[1] = q[1];
        if (slot == 4'd8) begin
          lv[0] = (cmd == CmdWrite) ? 1'b1 : ack_send;
        end else begin
          lv[0] = (cmd == CmdWrite) ? tx[3'd7 - slot[2:0]] : 1'b1;
        end
      end
      default: lv = 2'b11;
    endcase
    return lv;
  endfunction

  // A slave holding SCL low freezes any quarter in which we have released SCL.
  assign stall = scl_q & ~i_scl_read;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    quarter_d  = quarter_q;
    cnt_d      = cnt_q;
    slot_d     = slot_q;
    tx_d       = tx_q;
    ack_send_d = ack_send_q;
    rx_d       = rx_q;
    ack_rcvd_d = ack_rcvd_q;
    scl_d      = scl_q;
    sda_d      = sda_q;
    done_d     = 1'b0;
    arb_d      = 1'b0;
    arb_hit    = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_valid) begin
          cmd_d      = cmd_e'(i_cmd);
          tx_d       = i_tx_data;
          ack_send_d = i_ack_send;
          quarter_d  = 2'd0;
          slot_d     = 4'd0;
          cnt_d      = Reload;
          case (cmd_e'(i_cmd))
            CmdStart: state_d = StStart;
            CmdStop:  state_d = StStop;
            default:  state_d = StBit;
          endcase
          {scl_d, sda_d} = line_levels(state_d, 2'd0, 4'd0, cmd_e'(i_cmd), i_tx_data,
                                       i_ack_send);
        end
      end
      default: begin
        if (!stall) begin
          if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
          end else begin
            // Last cycle of Q2 is the SDA sample point of every bit slot.
            if (state_q == StBit && quarter_q == 2'd2) begin
              if (slot_q == 4'd8) begin
                if (cmd_q == CmdWrite) ack_rcvd_d = i_sda_read;
              end else if (cmd_q == CmdRead) begin
                rx_d = {rx_q[6:0], i_sda_read};
              end else if (sda_q && !i_sda_read) begin
                arb_hit = 1'b1;
              end
            end

            if (arb_hit) begin
              state_d   = StIdle;
              quarter_d = 2'd0;
              slot_d    = 4'd0;
              scl_d     = 1'b1;
              sda_d     = 1'b1;
              arb_d     = 1'b1;
            end else if (quarter_q == 2'd3 && (state_q != StBit || slot_q == 4'd8)) begin
              // Lines keep their last levels so the bus stays owned between commands.
              state_d   = StIdle;
              quarter_d = 2'd0;
              slot_d    = 4'd0;
              done_d    = 1'b1;
            end else begin
              quarter_d = quarter_q + 2'd1;
              slot_d    = (quarter_q == 2'd3) ? slot_q + 4'd1 : slot_q;
              cnt_d     = Reload;
              {scl_d, sda_d} = line_levels(state_q, quarter_d, slot_d, cmd_q, tx_q,
                                           ack_send_q);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      cmd_q      <= CmdStart;
      quarter_q  <= 2'd0;
      cnt_q      <= 16'd0;
      slot_q     <= 4'd0;
      tx_q       <= 8'd0;
      ack_send_q <= 1'b0;
      rx_q       <= 8'd0;
      ack_rcvd_q <= 1'b0;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      done_q     <= 1'b0;
      arb_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      quarter_q  <= quarter_d;
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      tx_q       <= tx_d;
      ack_send_q <= ack_send_d;
      rx_q       <= rx_d;
      ack_rcvd_q <= ack_rcvd_d;
      scl_q      <= scl_d;
      sda_q      <= sda_d;
      done_q     <= done_d;
      arb_q      <= arb_d;
    end
  end

  assign o_ready     = (state_q == StIdle);
  assign o_done      = done_q;
  assign o_arb_lost  = arb_q;
  assign o_rx_data   = rx_q;
  assign o_ack_rcvd  = ack_rcvd_q;
  assign o_scl_write = scl_q;
  assign o_sda_write = sda_q;

endmodule
